write_pointer_full: RTL and testbench

Write-domain pointer and full-flag generator for the dual-clock asynchronous FIFO. It is the write-side counterpart of the read pointer logic. It keeps the binary write counter and the Gray-coded write pointer that is exported to the read domain, and it addresses the shared memory. It also synchronizes the read domain's Gray pointer, then derives full, almost-full, fill level and a sticky overflow flag from it.

---
 rtl/write_pointer_full.sv | 79 +++++++
 tb/tb_write_pointer_full.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/write_pointer_full.sv
// Write-side pointer, Gray export and full/almost-full/level/overflow
// generation for a dual-clock FIFO, synchronizing the read Gray pointer.
module write_pointer_full #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic                 w_en,
    input  logic [ADDR_SIZE:0]   r_ptr,
    output logic                 w_inc,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic [ADDR_SIZE:0]   w_ptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   w_level,
    output logic                 overflow
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AF_LEVEL =
        (ADDR_SIZE+1)'(DEPTH - AFULL_THRESH);

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] rq1;
    logic [ADDR_SIZE:0] rq2;
    logic [ADDR_SIZE:0] bin_next;
    logic [ADDR_SIZE:0] gray_next;
    logic [ADDR_SIZE:0] rbin_s;
    logic [ADDR_SIZE:0] diff;
    logic [ADDR_SIZE:0] full_ptr;

    assign w_inc     = w_en & ~full & ~w_rst;
    assign w_addr    = wbin[ADDR_SIZE-1:0];
    assign bin_next  = wbin + (ADDR_SIZE+1)'(w_en & ~full);
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign diff      = bin_next - rbin_s;

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_ptr = {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]};

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= r_ptr;
            rq2 <= rq1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wbin        <= '0;
            w_ptr       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= bin_next;
            w_ptr       <= gray_next;
            full        <= (gray_next == full_ptr);
            almost_full <= (diff >= AF_LEVEL);
            w_level     <= diff;
            if (w_en & full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_pointer_full.sv
// Randomized self-checking bench for write_pointer_full against a
// count-based occupancy model with a two-edge read visibility delay.
module tb_write_pointer_full;

    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int LAP   = 32;
    localparam int AFT   = 2;

    logic         w_clk = 1'b0;
    logic         w_rst;
    logic         w_en;
    logic [A:0]   r_ptr;
    logic         w_inc;
    logic [A-1:0] w_addr;
    logic [A:0]   w_ptr;
    logic         full;
    logic         almost_full;
    logic [A:0]   w_level;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: counts of words written and read, read count seen with lag.
    int wr, rd, seen1, seen2, m_lvl;
    bit m_full, m_af, m_ovf;

    write_pointer_full #(.ADDR_SIZE(A), .AFULL_THRESH(AFT)) dut (
        .w_clk(w_clk),
        .w_rst(w_rst),
        .w_en(w_en),
        .r_ptr(r_ptr),
        .w_inc(w_inc),
        .w_addr(w_addr),
        .w_ptr(w_ptr),
        .full(full),
        .almost_full(almost_full),
        .w_level(w_level),
        .overflow(overflow)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [A:0] to_gray(input int n);
        logic [A:0] b;
        b = (A+1)'(n % LAP);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_edge();
        if (w_rst) begin
            wr = 0; seen1 = 0; seen2 = 0; m_lvl = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (w_en && m_full) m_ovf = 1;
            if (w_en && !m_full) wr++;
            m_lvl  = (((wr - seen2) % LAP) + LAP) % LAP;
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= DEPTH - AFT);
            seen2  = seen1;
            seen1  = rd;
        end
    endtask

    // Inputs are already driven (after a negedge); one full clock cycle.
    task automatic tick();
        r_ptr = to_gray(rd);
        #1;
        check("w_inc", w_inc, w_en && !m_full && !w_rst);
        @(posedge w_clk);
        model_edge();
        #1;
        check("w_ptr", w_ptr, to_gray(wr));
        check("w_addr", w_addr, wr % DEPTH);
        check("full", full, m_full);
        check("almost_full", almost_full, m_af);
        check("w_level", w_level, m_lvl);
        check("overflow", overflow, m_ovf);
        @(negedge w_clk);
    endtask

    task automatic do_reset();
        w_rst = 1; w_en = 0; rd = 0;
        tick(); tick();
        w_rst = 0;
    endtask

    initial begin
        wr = 0; rd = 0; seen1 = 0; seen2 = 0; m_lvl = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        w_rst = 1; w_en = 0; r_ptr = '0;
        @(negedge w_clk);

        // Reset then idle
        do_reset();
        tick();
        check("idle_ptr", w_ptr, 0);
        check("idle_lvl", w_level, 0);

        // Fill 16 deep with reader parked at 0
        w_en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 13) check("af_13", almost_full, 0);
            if (i == 14) check("af_14", almost_full, 1);
            if (i == 15) check("full_15", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_ptr", w_ptr, 5'b11000);
        check("fill_lvl", w_level, 16);

        // Write attempts while full
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_hold", overflow, 1);
            check("ovf_ptr", w_ptr, 5'b11000);
        end
        check("ovf_lvl", w_level, 16);

        // Reader frees 4 slots
        w_en = 0; rd = 4;
        tick(); check("free_e1", full, 1);
        tick(); check("free_e2", full, 1);
        tick(); check("free_e3", full, 0);
        check("free_af", almost_full, 0);
        check("free_lvl", w_level, 12);

        // Wrap-around with reader trailing by 8
        do_reset();
        w_en = 1;
        for (int i = 0; i < 40; i++) begin
            rd = (wr > 8) ? wr - 8 : 0;
            tick();
            check("wrap_nofull", full, 0);
        end
        w_en = 0;
        rd = wr - 8;
        tick(); tick(); tick();
        check("wrap_lvl", w_level, 8);
        check("wrap_addr", w_addr, 8);

        // Random traffic, reader never passes the writer
        for (int i = 0; i < 400; i++) begin
            w_en = ($urandom_range(0, 3) != 0);
            if (rd < wr && $urandom_range(0, 2) == 0) rd++;
            tick();
        end

        // Reset in the middle of a fill
        do_reset();
        w_en = 1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_addr", w_addr, 7);
        w_rst = 1;
        tick();
        check("mid_ptr", w_ptr, 0);
        check("mid_lvl", w_level, 0);
        check("mid_ovf", overflow, 0);
        w_rst = 0; w_en = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
